// File: rtl/cc_branch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cc_branch_unit_pkg
//  Brief    : Shared constants for the condition-code branch unit: condition
//             select encoding, CCR bit positions and FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package cc_branch_unit_pkg;

  // Condition select encoding
  localparam logic [3:0] COND_T  = 4'd0;
  localparam logic [3:0] COND_F  = 4'd1;
  localparam logic [3:0] COND_HI = 4'd2;
  localparam logic [3:0] COND_LS = 4'd3;
  localparam logic [3:0] COND_CC = 4'd4;
  localparam logic [3:0] COND_CS = 4'd5;
  localparam logic [3:0] COND_NE = 4'd6;
  localparam logic [3:0] COND_EQ = 4'd7;
  localparam logic [3:0] COND_VC = 4'd8;
  localparam logic [3:0] COND_VS = 4'd9;
  localparam logic [3:0] COND_PL = 4'd10;
  localparam logic [3:0] COND_MI = 4'd11;
  localparam logic [3:0] COND_GE = 4'd12;
  localparam logic [3:0] COND_LT = 4'd13;
  localparam logic [3:0] COND_GT = 4'd14;
  localparam logic [3:0] COND_LE = 4'd15;

  // Bit positions of the flags inside the CCR
  localparam int CCR_N = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_V = 1;
  localparam int CCR_C = 0;

  // Request sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cc_branch_unit_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module   : cc_cond_eval
//  Brief    : Combinational branch-condition evaluator, (NZVC, cond) -> true.
//  Revision : 1.0  initial release
// ============================================================================
module cc_cond_eval
  import cc_branch_unit_pkg::*;
(
  input  logic [3:0] i_nzvc,
  input  logic [3:0] i_cond,
  output logic       o_cond_true
);

  logic w_n, w_z, w_v, w_c;

  assign w_n = i_nzvc[CCR_N];
  assign w_z = i_nzvc[CCR_Z];
  assign w_v = i_nzvc[CCR_V];
  assign w_c = i_nzvc[CCR_C];

  // Decode the selected condition from the four flags
  always_comb begin
    o_cond_true = 1'b0;
    case (i_cond)
      COND_T:  o_cond_true = 1'b1;
      COND_F:  o_cond_true = 1'b0;
      COND_HI: o_cond_true = ~w_c & ~w_z;
      COND_LS: o_cond_true = w_c | w_z;
      COND_CC: o_cond_true = ~w_c;
      COND_CS: o_cond_true = w_c;
      COND_NE: o_cond_true = ~w_z;
      COND_EQ: o_cond_true = w_z;
      COND_VC: o_cond_true = ~w_v;
      COND_VS: o_cond_true = w_v;
      COND_PL: o_cond_true = ~w_n;
      COND_MI: o_cond_true = w_n;
      COND_GE: o_cond_true = w_n ~^ w_v;
      COND_LT: o_cond_true = w_n ^ w_v;
      COND_GT: o_cond_true = ~w_z & (w_n ~^ w_v);
      COND_LE: o_cond_true = w_z | (w_n ^ w_v);
      default: o_cond_true = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cc_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cc_branch_unit
//  Brief    : Condition-code register plus Bcc / DBcc evaluator with
//             valid/ready handshakes on request and response.
//  Revision : 1.0  initial release
// ============================================================================
module cc_branch_unit
  import cc_branch_unit_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_we,
  input  logic [3:0]       flag_nzvc,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cond,
  input  logic             req_dbcc,
  input  logic [NBITS-1:0] req_count,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_taken,
  output logic [NBITS-1:0] resp_count,
  output logic [3:0]       ccr_nzvc
);

  localparam logic [NBITS-1:0] C_ONE = {{(NBITS-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_ccr;
  logic [3:0]       r_cond;
  logic             r_dbcc;
  logic [NBITS-1:0] r_count;
  logic             r_taken;
  logic [NBITS-1:0] r_resp_count;
  logic             w_cond_true;
  logic [NBITS-1:0] w_count_dec;

  cc_cond_eval u_cond_eval (
    .i_nzvc      (r_ccr),
    .i_cond      (r_cond),
    .o_cond_true (w_cond_true)
  );

  assign w_count_dec = r_count - C_ONE;

  // CCR follows the ALU flag strobe regardless of request sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ccr <= 4'b0000;
    end else if (flag_we) begin
      r_ccr <= flag_nzvc;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake outputs; a new request is only taken in IDLE
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next_state = ST_EVAL;
        end
      end
      ST_EVAL: begin
        w_next_state = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Capture the request fields on the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cond  <= 4'b0000;
      r_dbcc  <= 1'b0;
      r_count <= '0;
    end else if (r_state == ST_IDLE && req_valid) begin
      r_cond  <= req_cond;
      r_dbcc  <= req_dbcc;
      r_count <= req_count;
    end
  end

  // Evaluate against the CCR as it stands during EVAL; hold until next EVAL.
  // DBcc decrements only when the condition is false and stops the loop when
  // the counter wraps from zero to all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken      <= 1'b0;
      r_resp_count <= '0;
    end else if (r_state == ST_EVAL) begin
      if (!r_dbcc) begin
        r_taken      <= w_cond_true;
        r_resp_count <= r_count;
      end else if (w_cond_true) begin
        r_taken      <= 1'b0;
        r_resp_count <= r_count;
      end else begin
        r_taken      <= ~(&w_count_dec);
        r_resp_count <= w_count_dec;
      end
    end
  end

  assign resp_taken = r_taken;
  assign resp_count = r_resp_count;
  assign ccr_nzvc   = r_ccr;

endmodule
`default_nettype wire

// File: tb/tb_cc_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cc_branch_unit
//  Brief    : Self-checking bench for cc_branch_unit with a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cc_branch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flag_we = 1'b0;
  logic [3:0] flag_nzvc = 4'h0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_cond = 4'h0;
  logic       req_dbcc = 1'b0;
  logic [7:0] req_count = 8'h00;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic       resp_taken;
  logic [7:0] resp_count;
  logic [3:0] ccr_nzvc;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cc_branch_unit #(.NBITS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flag_we    (flag_we),
    .flag_nzvc  (flag_nzvc),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cond   (req_cond),
    .req_dbcc   (req_dbcc),
    .req_count  (req_count),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_taken (resp_taken),
    .resp_count (resp_count),
    .ccr_nzvc   (ccr_nzvc)
  );

  // Reference: interpret flags as results of a compare a-b
  function automatic bit model_cond(input logic [3:0] nzvc, input int cond);
    bit equal, uns_lower, s_less, neg, ovf;
    neg       = nzvc[3];
    equal     = nzvc[2];
    ovf       = nzvc[1];
    uns_lower = nzvc[0];
    s_less    = (neg != ovf);
    case (cond)
      0:  return 1'b1;
      1:  return 1'b0;
      2:  return !(uns_lower || equal);
      3:  return uns_lower || equal;
      4:  return !uns_lower;
      5:  return uns_lower;
      6:  return !equal;
      7:  return equal;
      8:  return !ovf;
      9:  return ovf;
      10: return !neg;
      11: return neg;
      12: return !s_less;
      13: return s_less;
      14: return !s_less && !equal;
      default: return s_less || equal;
    endcase
  endfunction

  // Reference: loop exits when the condition holds or the counter was zero
  task automatic model(input logic [3:0] nzvc, input int cond, input bit dbcc,
                       input int count, output bit tk, output int cnt);
    bit c;
    c = model_cond(nzvc, cond);
    if (!dbcc) begin
      tk = c; cnt = count;
    end else if (c) begin
      tk = 1'b0; cnt = count;
    end else begin
      cnt = (count + 255) % 256;
      tk  = (count != 0);
    end
  endtask

  // Called right after a negedge
  task automatic write_ccr(input logic [3:0] v);
    flag_we = 1'b1; flag_nzvc = v;
    @(negedge clk);
    flag_we = 1'b0;
  endtask

  // Full request/response handshake; returns what the DUT presented
  task automatic run_req(input logic [3:0] cond, input bit dbcc, input logic [7:0] cnt_in,
                         input bit we_acc, input bit we_eval, input logic [3:0] wv,
                         output bit got, output int lat, output logic tk, output logic [7:0] cnt);
    req_valid = 1'b1; req_cond = cond; req_dbcc = dbcc; req_count = cnt_in;
    flag_we = we_acc; flag_nzvc = wv;
    @(negedge clk);
    req_valid = 1'b0; flag_we = we_eval;
    lat = 1; got = 1'b0;
    while (lat < 12 && !got) begin
      @(negedge clk);
      flag_we = 1'b0;
      lat++;
      if (resp_valid === 1'b1) got = 1'b1;
    end
    tk = resp_taken; cnt = resp_count;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (req_ready !== 1'b1)   $display("FAIL reset_req_ready: got %b want 1", req_ready);   else passed++;
    total++; if (resp_valid !== 1'b0)  $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else passed++;
    total++; if (resp_taken !== 1'b0)  $display("FAIL reset_resp_taken: got %b want 0", resp_taken); else passed++;
    total++; if (resp_count !== 8'h00) $display("FAIL reset_resp_count: got %h want 00", resp_count); else passed++;
    total++; if (ccr_nzvc !== 4'h0)    $display("FAIL reset_ccr: got %b want 0000", ccr_nzvc);      else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_bcc_hi();
    bit got; int lat; logic tk; logic [7:0] c;
    write_ccr(4'b0000);
    run_req(4'd2, 1'b0, 8'h42, 1'b0, 1'b0, 4'h0, got, lat, tk, c);
    total++; if (lat !== 2)      $display("FAIL hi_latency: got %0d want 2", lat);   else passed++;
    total++; if (tk !== 1'b1)    $display("FAIL hi_taken: got %b want 1", tk);       else passed++;
    total++; if (c !== 8'h42)    $display("FAIL hi_count: got %h want 42", c);       else passed++;
    total++; if (ccr_nzvc !== 4'b0000) $display("FAIL hi_ccr: got %b want 0000", ccr_nzvc); else passed++;
  endtask

  task automatic test_cond_sweep();
    bit got; int lat; logic tk; logic [7:0] c, cin; bit etk; int ecnt;
    for (int f = 0; f < 16; f++) begin
      for (int k = 0; k < 16; k++) begin
        cin = 8'($urandom);
        write_ccr(4'(f));
        run_req(4'(k), 1'b0, cin, 1'b0, 1'b0, 4'h0, got, lat, tk, c);
        model(4'(f), k, 1'b0, int'(cin), etk, ecnt);
        total++; if (!got) $display("FAIL sweep_resp nzvc=%0d cond=%0d: no response", f, k); else passed++;
        total++; if (tk !== etk) $display("FAIL sweep_taken nzvc=%0d cond=%0d: got %b want %b", f, k, tk, etk); else passed++;
        total++; if (c !== 8'(ecnt)) $display("FAIL sweep_count nzvc=%0d cond=%0d: got %h want %h", f, k, c, 8'(ecnt)); else passed++;
      end
    end
  endtask

  task automatic test_dbcc();
    bit got; int lat; logic tk; logic [7:0] c, cin; logic [3:0] f, k; bit etk; int ecnt;
    write_ccr(4'b0000);
    run_req(4'd1, 1'b1, 8'd3, 1'b0, 1'b0, 4'h0, got, lat, tk, c);
    total++; if (tk !== 1'b1 || c !== 8'd2) $display("FAIL dbcc_f3: got tk=%b cnt=%h want tk=1 cnt=02", tk, c); else passed++;
    run_req(4'd1, 1'b1, 8'd0, 1'b0, 1'b0, 4'h0, got, lat, tk, c);
    total++; if (tk !== 1'b0 || c !== 8'hFF) $display("FAIL dbcc_f0: got tk=%b cnt=%h want tk=0 cnt=ff", tk, c); else passed++;
    write_ccr(4'b0100);
    run_req(4'd7, 1'b1, 8'd5, 1'b0, 1'b0, 4'h0, got, lat, tk, c);
    total++; if (tk !== 1'b0 || c !== 8'd5) $display("FAIL dbcc_eq: got tk=%b cnt=%h want tk=0 cnt=05", tk, c); else passed++;
    for (int i = 0; i < 40; i++) begin
      f = 4'($urandom); k = 4'($urandom);
      cin = ($urandom_range(0, 3) == 0) ? 8'(($urandom_range(0, 2))) : 8'($urandom);
      write_ccr(f);
      run_req(k, 1'b1, cin, 1'b0, 1'b0, 4'h0, got, lat, tk, c);
      model(f, int'(k), 1'b1, int'(cin), etk, ecnt);
      total++; if (!got || tk !== etk || c !== 8'(ecnt))
        $display("FAIL dbcc_rand nzvc=%b cond=%0d cnt=%h: got v=%b tk=%b cnt=%h want tk=%b cnt=%h",
                 f, k, cin, got, tk, c, etk, 8'(ecnt));
      else passed++;
    end
  endtask

  task automatic test_forwarding();
    bit got; int lat; logic tk; logic [7:0] c;
    write_ccr(4'b0000);
    run_req(4'd7, 1'b0, 8'h11, 1'b1, 1'b0, 4'b0100, got, lat, tk, c);
    total++; if (tk !== 1'b1) $display("FAIL fwd_accept_cycle: got %b want 1", tk); else passed++;
    write_ccr(4'b0000);
    run_req(4'd7, 1'b0, 8'h11, 1'b0, 1'b1, 4'b0100, got, lat, tk, c);
    total++; if (tk !== 1'b0) $display("FAIL fwd_eval_cycle: got %b want 0", tk); else passed++;
    total++; if (ccr_nzvc !== 4'b0100) $display("FAIL fwd_ccr_after: got %b want 0100", ccr_nzvc); else passed++;
  endtask

  task automatic test_backpressure();
    logic st; logic [7:0] sc; bit stable;
    write_ccr(4'b0100);
    req_valid = 1'b1; req_cond = 4'd6; req_dbcc = 1'b1; req_count = 8'h10;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    total++; if (resp_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", resp_valid); else passed++;
    st = resp_taken; sc = resp_count;
    total++; if (st !== 1'b1 || sc !== 8'h0F) $display("FAIL bp_result: got tk=%b cnt=%h want tk=1 cnt=0f", st, sc); else passed++;
    req_valid = 1'b1; req_cond = 4'd7; req_dbcc = 1'b0; req_count = 8'hA5;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_taken !== st || resp_count !== sc || req_ready !== 1'b0) stable = 1'b0;
    end
    total++; if (!stable) $display("FAIL bp_stable: got outputs changed want held"); else passed++;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", resp_valid, req_ready); else passed++;
    @(negedge clk);
    req_valid = 1'b0;
    total++; if (req_ready !== 1'b0) $display("FAIL bp_held_accept: got rdy=%b want 0", req_ready); else passed++;
    @(negedge clk);
    total++; if (resp_valid !== 1'b1 || resp_taken !== 1'b1 || resp_count !== 8'hA5)
      $display("FAIL bp_held_result: got v=%b tk=%b cnt=%h want v=1 tk=1 cnt=a5", resp_valid, resp_taken, resp_count);
    else passed++;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen; bit got; int lat; logic tk; logic [7:0] c;
    write_ccr(4'hF);
    req_valid = 1'b1; req_cond = 4'd0; req_dbcc = 1'b0; req_count = 8'h33;
    @(negedge clk);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || ccr_nzvc !== 4'h0)
      $display("FAIL rstmid_async: got v=%b rdy=%b ccr=%b want v=0 rdy=1 ccr=0000", resp_valid, req_ready, ccr_nzvc);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    resp_ready = 1'b0;
    total++; if (seen) $display("FAIL rstmid_no_resp: got resp_valid=1 want 0"); else passed++;
    run_req(4'd0, 1'b0, 8'h77, 1'b0, 1'b0, 4'h0, got, lat, tk, c);
    total++; if (!got || tk !== 1'b1 || c !== 8'h77) $display("FAIL rstmid_recover: got v=%b tk=%b cnt=%h want v=1 tk=1 cnt=77", got, tk, c); else passed++;
  endtask

  initial begin
    test_reset();
    test_bcc_hi();
    test_cond_sweep();
    test_dbcc();
    test_forwarding();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cc_branch_unit.md
Name: cc_branch_unit

Overview:
- Consumes the NZVC condition codes produced by the 8-bit adder/subtractor and answers branch-condition queries.
- Holds a 4-bit condition-code register (CCR) that the ALU writes, and evaluates one of 16 conditions per request.
- Optionally executes a decrement-and-branch (DBcc) loop-counter step.
- Sits between the ALU flag outputs and the sequencer's branch logic; valid/ready handshake on both request and response.

Parameters:
NBITS, 8, width of loop counter (matches ALU datapath width)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
flag_we  input  1  write strobe for CCR
flag_nzvc  input  4  {N,Z,V,C} from ALU; C is borrow after subtract
req_valid  input  1  request present
req_ready  output  1  unit can accept request
req_cond  input  4  condition select (encoding below)
req_dbcc  input  1  1 = DBcc operation, 0 = plain Bcc
req_count  input  NBITS  loop counter value for DBcc
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_taken  output  1  branch taken
resp_count  output  NBITS  updated loop counter (DBcc) or req_count passthrough
ccr_nzvc  output  4  current CCR contents

Behaviour:
- Reset (async, rst_n=0): CCR=4'b0000, state=IDLE, req_ready=1, resp_valid=0, resp_taken=0, resp_count=0. Reset mid-operation discards the in-flight request; no response is produced.
- CCR: on a clk edge with flag_we=1, CCR<=flag_nzvc. Independent of the FSM; writable in any state.
- Forwarding: the condition is evaluated against CCR as it stands in the EVAL cycle. A flag_we in the accept cycle is therefore visible (CCR is updated at that edge). A flag_we in the EVAL cycle is not visible.
- Condition encoding, with N,Z,V,C from CCR:
  - 0 T=1
  - 1 F=0
  - 2 HI=!C&!Z
  - 3 LS=C|Z
  - 4 CC=!C
  - 5 CS=C
  - 6 NE=!Z
  - 7 EQ=Z
  - 8 VC=!V
  - 9 VS=V
  - 10 PL=!N
  - 11 MI=N
  - 12 GE=N~^V
  - 13 LT=N^V
  - 14 GT=!Z&(N~^V)
  - 15 LE=Z|(N^V)
- FSM states IDLE, EVAL, RESP:
  - IDLE: req_ready=1. req_valid=1 latches req_cond, req_dbcc and req_count, then moves to EVAL.
  - EVAL: req_ready=0. Computes the result registers (rules below), then moves to RESP.
  - RESP: resp_valid=1; outputs held stable until resp_ready=1. On that edge, resp_valid drops and the FSM returns to IDLE.
- No back-to-back accept in RESP. Throughput is one request per 3 cycles minimum.
- Latency: resp_valid asserts 2 cycles after the accept edge.
- Bcc (req_dbcc=0): resp_taken=cond, resp_count=req_count.
- DBcc (req_dbcc=0 rules do not apply):
  - cond=1: resp_taken=0, resp_count=req_count (loop exits).
  - cond=0: resp_count=req_count-1 modulo 2^NBITS.
  - resp_taken=1 unless the new count equals all-ones (wrap from 0 to 2^NBITS-1 terminates the loop, taken=0).
- resp_taken and resp_count are registered; they are don't-care outside RESP but keep their last value.

Decomposition:
- Shared package: condition code constants COND_T..COND_LE (4-bit), FSM state encoding, CCR bit indices N=3, Z=2, V=1, C=0.
- One natural sub-module: cc_cond_eval, combinational, (nzvc[3:0], cond[3:0]) -> cond_true. Reusable by the sequencer and the testbench golden model.

Test Plan:
- CCR write then Bcc HI: flag_nzvc=0000 (0x05-0x03=0x02), req_cond=2 -> resp_taken=1 two cycles after accept; ccr_nzvc=0000.
- Signed vs unsigned compare: flag_nzvc=1001 (0x03-0x05=0xFE, borrow) -> cond CS=1, LT=1, HI=0, GE=0. flag_nzvc=0010 (0x80-0x01=0x7F, V set) -> LT=1, CS=0. Sweep all 16 conds against cc_cond_eval for all 16 NZVC values.
- DBcc: cond F, req_count=3 -> resp_count=2, taken=1. Cond F, req_count=0 -> resp_count=0xFF, taken=0. Cond EQ with Z=1, req_count=5 -> resp_count=5, taken=0.
- Forwarding/ordering: CCR=0000, flag_we=1 with flag_nzvc=0100 in the accept cycle, cond EQ -> taken=1. Same stimulus but flag_we in the EVAL cycle -> taken=0.
- Backpressure: resp_ready=0 for 10 cycles -> resp_valid, resp_taken and resp_count stable, req_ready=0 throughout. New req_valid is held off and accepted only after return to IDLE.
- Reset mid-operation: assert rst_n=0 during EVAL -> resp_valid=0, req_ready=1, ccr_nzvc=0000 immediately (asynchronous); no response after release.
